axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Two-master to one-slave AXI-lite read-channel arbiter (AR/R only). It shares the single memory read port between the instruction fetch unit (M0) and the load/store unit (M1).
- Sits between the IFU/LSU read masters and the memory/SRAM slave.
- Serialises transactions: one outstanding read at a time, round-robin fairness, and R responses are routed back to the granted master only.

Parameters:
- ADDR_W, 32, width of AR address bus
- DATA_W, 32, width of R data bus
- RR_INIT, 1, reset value of last_grant (1 means M0 wins the first tie)

Ports:
- clk_i  input  1  clock; all state updates on posedge
- rst_i  input  1  reset, synchronous, active-low (rst_i==0 at posedge resets)
- m0_ar_valid_i / m1_ar_valid_i  input  1  master read-address valid
- m0_ar_addr_i / m1_ar_addr_i  input  ADDR_W  master read address
- m0_ar_ready_o / m1_ar_ready_o  output  1  address accepted
- m0_r_valid_o / m1_r_valid_o  output  1  read data valid to master
- m0_r_data_o / m1_r_data_o  output  DATA_W  read data (both = s_r_data_i)
- m0_r_resp_o / m1_r_resp_o  output  2  read response (both = s_r_resp_i)
- m0_r_ready_i / m1_r_ready_i  input  1  master ready for data
- s_ar_valid_o  output  1  slave read-address valid
- s_ar_addr_o  output  ADDR_W  slave read address
- s_ar_ready_i  input  1  slave address ready
- s_r_valid_i  input  1  slave data valid
- s_r_data_i  input  DATA_W  slave read data
- s_r_resp_i  input  2  slave response
- s_r_ready_o  output  1  ready to slave
- grant_o  output  2  one-hot current owner: 01 = M0, 10 = M1, 00 = idle
- busy_o  output  1  transaction in flight (state != IDLE)

Behaviour:
- Registers:
  - state, one-hot: IDLE, ADDR, DATA.
  - sel (1 bit, granted master).
  - last_grant (1 bit).
- Reset (rst_i==0 at posedge):
  - state=IDLE, sel=0, last_grant=RR_INIT.
  - All valid/ready outputs are 0 combinationally in IDLE. grant_o=00, busy_o=0.
  - Reset mid-transaction abandons it. The slave shares the same reset.
- IDLE:
  - No outputs asserted and no ready returned to either master.
  - Only M0 valid: sel<=0. Only M1 valid: sel<=1.
  - Both valid: sel<=~last_grant.
  - Any valid: next state ADDR. Otherwise stay in IDLE.
- ADDR:
  - s_ar_valid_o = mSEL_ar_valid_i; s_ar_addr_o = mSEL_ar_addr_i.
  - mSEL_ar_ready_o = s_ar_ready_i. The other master's ar_ready=0.
  - On s_ar_valid_o & s_ar_ready_i: next state DATA.
  - Masters must hold valid and addr stable until ready (AXI rule). If the granted master drops valid, the arbiter forwards the drop and stays in ADDR. There is no re-arbitration.
- DATA:
  - mSEL_r_valid_o = s_r_valid_i. The other master's r_valid=0.
  - s_r_ready_o = mSEL_r_ready_i.
  - On s_r_valid_i & s_r_ready_o: next state IDLE, last_grant<=sel.
- Data and resp are broadcast to both masters ungated. Only valid is steered.
- s_ar_valid_o=0 outside ADDR. s_r_ready_o=0 and both r_valid=0 outside DATA.
- A slave r_valid seen outside DATA is not acknowledged. It is a slave protocol error and the arbiter does not flag it.
- grant_o = (state!=IDLE) ? onehot(sel) : 00.
- Latency:
  - Request in IDLE at cycle t drives s_ar_valid_o at t+1.
  - Minimum occupancy is 3 cycles per read (IDLE, ADDR, DATA with zero-wait slave).
  - One mandatory IDLE bubble between transactions, so no back-to-back reads.
- Fairness: under continuous requests from both masters, grants alternate M0, M1, M0, ... A master waits at most one other transaction.
- Responses pass through unmodified, including SLVERR (2'b10).

Test Plan:
- Single M0 read, zero-wait slave: m0 ar addr 0x8000_0000, slave returns 0x0000_0413 resp 00 → s_ar_valid high at cycle 1, m0_r_valid at cycle 2 with data 0x0000_0413, m1_r_valid stays 0, grant_o=01 for 2 cycles.
- Simultaneous first requests: M0 addr 0x8000_0000 and M1 addr 0x8000_0100 in IDLE → M0 served first (RR_INIT=1), then M1. s_ar_addr_o sequence is 0x8000_0000, 0x8000_0100.
- Sustained contention: both masters hold valid for 6 transactions → grant order 01,10,01,10,01,10.
- Backpressure: slave ar_ready low 3 cycles, then master r_ready low 2 cycles while s_r_valid high → state holds ADDR 3 cycles, then DATA 2 extra cycles. No spurious handshake reaches the other master.
- Error passthrough: slave resp 2'b10 to an M1 read at 0x0000_0000 → m1_r_resp_o=10 and m1_r_valid_o=1. Arbiter returns to IDLE normally.
- Reset mid-DATA: rst_i=0 for 1 cycle while M1 waits for data → next cycle state IDLE, all valids/readies 0, grant_o=00. A subsequent M0 request is served normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// One AXI-lite read channel (AR + R). The master modport is the side that issues
// addresses; the slave modport is the side that returns data.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ar_valid;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_ready;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_ready;

    modport master (
        output ar_valid, ar_addr, r_ready,
        input  ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, r_ready,
        output ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master to one-slave AXI-lite read arbiter: one read in flight, round-robin
// between IFU (m0) and LSU (m1), responses steered back to the granted master.
//
// state | meaning
// IDLE  | no owner; pick a master from the pending AR valids
// ADDR  | forward granted master's AR to the slave until accepted
// DATA  | forward slave R to granted master until it takes the beat
module axi_rd_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter bit RR_INIT = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    axi_rd_arbiter_if.slave         m0,
    axi_rd_arbiter_if.slave         m1,
    axi_rd_arbiter_if.master        s,
    output logic [1:0]              grant_o,
    output logic                    busy_o
);

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        ADDR = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t            state;
    logic              sel;
    logic              last_grant;
    logic              win;
    logic              in_addr;
    logic              in_data;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    // On a tie the master that did not win last time gets the bus.
    assign win = (m0.ar_valid && m1.ar_valid) ? ~last_grant : m1.ar_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            sel        <= 1'b0;
            last_grant <= RR_INIT;
            grant_o    <= 2'b00;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.ar_valid || m1.ar_valid) begin
                        state   <= ADDR;
                        sel     <= win;
                        grant_o <= win ? 2'b10 : 2'b01;
                        busy_o  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (s.ar_valid && s.ar_ready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (s.r_valid && s.r_ready) begin
                        state      <= IDLE;
                        last_grant <= sel;
                        grant_o    <= 2'b00;
                        busy_o     <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= 2'b00;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    assign in_addr = (state == ADDR);
    assign in_data = (state == DATA);

    assign sel_addr   = sel ? m1.ar_addr : m0.ar_addr;
    assign s.ar_addr  = sel_addr;
    assign s.ar_valid = in_addr && (sel ? m1.ar_valid : m0.ar_valid);
    assign m0.ar_ready = in_addr && !sel && s.ar_ready;
    assign m1.ar_ready = in_addr &&  sel && s.ar_ready;

    // Only valid is steered; data and response go to both masters as-is.
    assign s.r_ready  = in_data && (sel ? m1.r_ready : m0.r_ready);
    assign m0.r_valid = in_data && !sel && s.r_valid;
    assign m1.r_valid = in_data &&  sel && s.r_valid;

    assign r_data    = s.r_data;
    assign r_resp    = s.r_resp;
    assign m0.r_data = r_data;
    assign m1.r_data = r_data;
    assign m0.r_resp = r_resp;
    assign m1.r_resp = r_resp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: directed reads from two master models into
// a slave model, expected beats queued at issue and matched at the master R ports.
module tb_axi_rd_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] grant_o;
    logic       busy_o;

    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_INIT(1'b1)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] req_q0[$];
    logic [31:0] req_q1[$];
    exp_t        exp_q[$];

    // stimulus-side configuration, written only by the test sequence
    int ar_stall_cfg = 0;
    int r_stall_cfg0 = 0;
    int r_stall_cfg1 = 0;
    int r_delay_cfg  = 0;

    // bus-model state, written only by the bfm process
    int          cyc = 0;
    int          t_ar = 0;
    int          t_r = 0;
    int          n_done = 0;
    int          addr_cyc = 0;
    int          data_cyc = 0;
    int          g0_cyc = 0;
    int          g1_cyc = 0;
    logic [1:0]  last_resp1 = 2'b00;
    int          ar_cnt = 0;
    int          r_cnt0 = 0;
    int          r_cnt1 = 0;
    int          slv_dly = 0;
    logic        slv_have = 1'b0;
    logic [31:0] slv_addr = '0;
    logic        ar_hs0 = 0, ar_hs1 = 0, s_ar_hs = 0, s_r_hs = 0;
    logic        r_hs0 = 0, r_hs1 = 0, s_ar_wait = 0, r_wait0 = 0, r_wait1 = 0;
    logic [31:0] ar_addr_smp = '0;

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return {a[15:0], 16'h0413};
    endfunction

    function automatic logic [1:0] slv_resp(input logic [31:0] a);
        return (a == 32'h0) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [1:0] oh(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic issue(input logic id, input logic [31:0] addr);
        exp_t e;
        e.id   = id;
        e.addr = addr;
        e.data = slv_data(addr);
        e.resp = slv_resp(addr);
        exp_q.push_back(e);
        if (id) req_q1.push_back(addr);
        else    req_q0.push_back(addr);
    endtask

    task automatic wait_done(input string tag);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk_i); #2;
            if (exp_q.size() == 0 && req_q0.size() == 0 && req_q1.size() == 0 && busy_o === 1'b0)
                done = 1;
        end
        if (!done) chk_eq({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic reset_pulse();
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk_eq({tag, "_grant"},  grant_o, 2'b00);
        chk_eq({tag, "_busy"},   busy_o, 1'b0);
        chk_eq({tag, "_s_arv"},  s_if.ar_valid, 1'b0);
        chk_eq({tag, "_s_rrdy"}, s_if.r_ready, 1'b0);
        chk_eq({tag, "_m_rv"},   {m1_if.r_valid, m0_if.r_valid}, 2'b00);
        chk_eq({tag, "_m_ardy"}, {m1_if.ar_ready, m0_if.ar_ready}, 2'b00);
    endtask

    // Bus model: inputs change on the falling edge, outputs are sampled 1 ns later,
    // and the handshakes seen there complete on the following rising edge.
    initial begin : bfm
        m0_if.ar_valid = 1'b0; m0_if.ar_addr = '0; m0_if.r_ready = 1'b1;
        m1_if.ar_valid = 1'b0; m1_if.ar_addr = '0; m1_if.r_ready = 1'b1;
        s_if.ar_ready  = 1'b1; s_if.r_valid  = 1'b0; s_if.r_data = '0; s_if.r_resp = 2'b00;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                req_q0.delete();
                req_q1.delete();
                exp_q.delete();
                slv_have = 1'b0;
            end else begin
                if (ar_hs0) void'(req_q0.pop_front());
                if (ar_hs1) void'(req_q1.pop_front());
                if (s_r_hs) slv_have = 1'b0;
                if (s_ar_hs) begin
                    slv_have = 1'b1;
                    slv_addr = ar_addr_smp;
                    slv_dly  = r_delay_cfg;
                end
                if (s_ar_wait && ar_cnt > 0) ar_cnt--;
                if (r_wait0 && r_cnt0 > 0) r_cnt0--;
                if (r_wait1 && r_cnt1 > 0) r_cnt1--;
            end
            if (busy_o === 1'b0) begin
                ar_cnt = ar_stall_cfg;
                r_cnt0 = r_stall_cfg0;
                r_cnt1 = r_stall_cfg1;
            end

            m0_if.ar_valid = (req_q0.size() != 0);
            if (req_q0.size() != 0) m0_if.ar_addr = req_q0[0];
            else                    m0_if.ar_addr = '0;
            m1_if.ar_valid = (req_q1.size() != 0);
            if (req_q1.size() != 0) m1_if.ar_addr = req_q1[0];
            else                    m1_if.ar_addr = '0;
            m0_if.r_ready = (r_cnt0 == 0);
            m1_if.r_ready = (r_cnt1 == 0);
            s_if.ar_ready = (ar_cnt == 0);
            if (slv_have && slv_dly == 0) begin
                s_if.r_valid = 1'b1;
                s_if.r_data  = slv_data(slv_addr);
                s_if.r_resp  = slv_resp(slv_addr);
            end else begin
                s_if.r_valid = 1'b0;
                s_if.r_data  = 32'hDEAD_BEEF;
                s_if.r_resp  = 2'b00;
                if (slv_have && slv_dly > 0) slv_dly--;
            end

            #1;
            if (rst_i) begin
                cyc++;
                ar_hs0      = m0_if.ar_valid && m0_if.ar_ready;
                ar_hs1      = m1_if.ar_valid && m1_if.ar_ready;
                s_ar_hs     = s_if.ar_valid && s_if.ar_ready;
                ar_addr_smp = s_if.ar_addr;
                s_r_hs      = s_if.r_valid && s_if.r_ready;
                r_hs0       = m0_if.r_valid && m0_if.r_ready;
                r_hs1       = m1_if.r_valid && m1_if.r_ready;
                s_ar_wait   = s_if.ar_valid && !s_if.ar_ready;
                r_wait0     = m0_if.r_valid && !m0_if.r_ready;
                r_wait1     = m1_if.r_valid && !m1_if.r_ready;

                if (s_ar_hs) begin
                    t_ar = cyc;
                    if (exp_q.size() == 0) chk_eq("ar_unexpected", 64'd1, 64'd0);
                    else begin
                        chk_eq("ar_addr",  s_if.ar_addr, exp_q[0].addr);
                        chk_eq("ar_grant", grant_o, oh(exp_q[0].id));
                        chk_eq("ar_route", {ar_hs1, ar_hs0}, oh(exp_q[0].id));
                    end
                end
                if (m0_if.r_valid || m1_if.r_valid) begin
                    if (exp_q.size() == 0) chk_eq("r_unexpected", 64'd1, 64'd0);
                    else chk_eq("r_route", {m1_if.r_valid, m0_if.r_valid}, oh(exp_q[0].id));
                end
                if ((r_hs0 || r_hs1) && exp_q.size() != 0) begin
                    chk_eq("r_data", exp_q[0].id ? m1_if.r_data : m0_if.r_data, exp_q[0].data);
                    chk_eq("r_resp", exp_q[0].id ? m1_if.r_resp : m0_if.r_resp, exp_q[0].resp);
                    chk_eq("s_r_ack", s_r_hs, 1'b1);
                    if (r_hs1) last_resp1 = m1_if.r_resp;
                    void'(exp_q.pop_front());
                    n_done++;
                    t_r = cyc;
                end
                if (s_if.ar_valid) addr_cyc++;
                if (busy_o && !s_if.ar_valid) data_cyc++;
                if (grant_o == 2'b01) g0_cyc++;
                if (grant_o == 2'b10) g1_cyc++;
            end else begin
                ar_hs0 = 0; ar_hs1 = 0; s_ar_hs = 0; s_r_hs = 0;
                r_hs0 = 0; r_hs1 = 0; s_ar_wait = 0; r_wait0 = 0; r_wait1 = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_done=%0d", n_done);
        $fatal(1, "watchdog expired");
    end

    initial begin : seq
        int t_push, base_a, base_d, base_g0, base_g1, base_n;

        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b1;
        chk_idle("reset");

        // simultaneous first requests: M0 wins the first tie
        t_push = cyc;
        issue(1'b0, 32'h8000_0000);
        issue(1'b1, 32'h8000_0100);
        wait_done("tie");
        chk_eq("tie_first_ar", t_ar - t_push, 64'd5);
        chk_eq("tie_last_r",   t_r - t_push,  64'd6);

        // single zero-wait M0 read
        reset_pulse();
        t_push  = cyc;
        base_g0 = g0_cyc;
        base_g1 = g1_cyc;
        base_a  = addr_cyc;
        base_d  = data_cyc;
        issue(1'b0, 32'h8000_0000);
        wait_done("single");
        chk_eq("single_ar_lat",  t_ar - (t_push + 1), 64'd1);
        chk_eq("single_r_lat",   t_r - (t_push + 1),  64'd2);
        chk_eq("single_g0_cyc",  g0_cyc - base_g0, 64'd2);
        chk_eq("single_g1_cyc",  g1_cyc - base_g1, 64'd0);
        chk_eq("single_addr_cyc", addr_cyc - base_a, 64'd1);
        chk_eq("single_data_cyc", data_cyc - base_d, 64'd1);

        // sustained contention: strict alternation with an idle bubble each time
        reset_pulse();
        t_push = cyc;
        base_n = n_done;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 32'h0000_1000 + 32'(4 * i));
            issue(1'b1, 32'h0000_2000 + 32'(4 * i));
        end
        wait_done("sustain");
        chk_eq("sustain_count", n_done - base_n, 64'd6);
        chk_eq("sustain_span",  t_r - t_push,    64'd18);

        // backpressure from the slave AR side then from the master R side
        reset_pulse();
        ar_stall_cfg = 3;
        r_stall_cfg0 = 2;
        @(posedge clk_i); #2;
        base_a = addr_cyc;
        base_d = data_cyc;
        issue(1'b0, 32'h8000_0300);
        wait_done("bp");
        chk_eq("bp_addr_cyc", addr_cyc - base_a, 64'd4);
        chk_eq("bp_data_cyc", data_cyc - base_d, 64'd3);
        ar_stall_cfg = 0;
        r_stall_cfg0 = 0;
        @(posedge clk_i); #2;

        // SLVERR passes through to M1
        issue(1'b1, 32'h0000_0000);
        wait_done("err");
        chk_eq("err_resp", last_resp1, 2'b10);
        chk_idle("err_after");

        // reset while M1 is waiting in DATA, then a normal M0 read
        r_delay_cfg = 6;
        issue(1'b1, 32'h0000_0040);
        begin
            bit in_data = 0;
            for (int i = 0; i < 50 && !in_data; i++) begin
                @(posedge clk_i); #2;
                if (busy_o === 1'b1 && s_if.ar_valid === 1'b0) in_data = 1;
            end
            chk_eq("rst_reach_data", in_data, 1'b1);
        end
        reset_pulse();
        chk_idle("rst_mid");
        r_delay_cfg = 0;
        @(posedge clk_i); #2;
        chk_idle("rst_mid_hold");
        base_n = n_done;
        issue(1'b0, 32'h8000_0200);
        wait_done("post_rst");
        chk_eq("post_rst_count", n_done - base_n, 64'd1);

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
